// File: rtl/blood_request_board.sv
// Blood request board.
// Keeps a saturating per-type count of waiting patients (8 ABO/Rh codes), drives
// the patient-waiting lines from those counts, and allocates one donor unit at a
// time by scanning candidate types from code 7 down to code 0.
module blood_request_board #(
    parameter int CNT_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    input  logic [2:0] req_type_i,
    output logic       req_ready_o,
    input  logic       don_valid_i,
    input  logic [2:0] don_type_i,
    output logic       don_ready_o,
    output logic       alloc_valid_o,
    output logic       alloc_hit_o,
    output logic [2:0] alloc_type_o,
    input  logic       alloc_ready_i,
    output logic [7:0] pend_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Type code is {rh, a, b}; every antigen carried by the donor must also be
    // carried by the patient, which covers both the ABO and the Rh rule at once.
    function automatic logic compatible(input logic [2:0] donor, input logic [2:0] patient);
        return (donor & ~patient) == 3'b000;
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [2:0]       don_q, don_d;
    logic             hit_q, hit_d;
    logic [2:0]       atype_q, atype_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    logic             req_fire;
    logic             scan_hit;

    assign req_ready_o = (cnt_q[req_type_i] != CNT_MAX);
    assign req_fire    = req_valid_i & req_ready_o;
    assign scan_hit    = (state_q == SCAN) && (cnt_q[idx_q] != '0) && compatible(don_q, idx_q);

    // State register together with the donor/scan/result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            don_q   <= 3'd0;
            hit_q   <= 1'b0;
            atype_q <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            don_q   <= don_d;
            hit_q   <= hit_d;
            atype_q <= atype_d;
        end
    end

    // Next-state logic: accept donor, scan one candidate per cycle, hold result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (don_valid_i) state_d = SCAN;
            SCAN:    if (scan_hit || (idx_q == 3'd0)) state_d = RESP;
            RESP:    if (alloc_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan index, latched donor and allocation result updates
    always_comb begin
        idx_d   = idx_q;
        don_d   = don_q;
        hit_d   = hit_q;
        atype_d = atype_q;
        case (state_q)
            IDLE: begin
                if (don_valid_i) begin
                    don_d = don_type_i;
                    idx_d = 3'd7;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    hit_d   = 1'b1;
                    atype_d = idx_q;
                end else if (idx_q == 3'd0) begin
                    hit_d   = 1'b0;
                    atype_d = 3'd0;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Per-type counters: enqueue and scan decrement on the same type cancel out
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            cnt_d[k] = cnt_q[k];
            if (req_fire && (req_type_i == 3'(k)) && !(scan_hit && (idx_q == 3'(k)))) begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end else if (scan_hit && (idx_q == 3'(k)) && !(req_fire && (req_type_i == 3'(k)))) begin
                cnt_d[k] = cnt_q[k] - CNT_ONE;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 8; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < 8; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // Outputs decoded from state and registered counts
    always_comb begin
        don_ready_o   = (state_q == IDLE);
        alloc_valid_o = (state_q == RESP);
        alloc_hit_o   = hit_q;
        alloc_type_o  = atype_q;
        for (int k = 0; k < 8; k++) pend_o[k] = (cnt_q[k] != '0);
    end

endmodule

// File: tb/tb_blood_request_board.sv
// Directed bench for blood_request_board: request counting, compatibility,
// priority order, latency, saturation/collision, backpressure and reset.
module tb_blood_request_board;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       req_valid;
    logic [2:0] req_type;
    logic       req_ready;
    logic       don_valid;
    logic [2:0] don_type;
    logic       don_ready;
    logic       alloc_valid;
    logic       alloc_hit;
    logic [2:0] alloc_type;
    logic       alloc_ready;
    logic [7:0] pend;

    int n_checks = 0;
    int n_fail   = 0;

    blood_request_board #(.CNT_W(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid),
        .req_type_i    (req_type),
        .req_ready_o   (req_ready),
        .don_valid_i   (don_valid),
        .don_type_i    (don_type),
        .don_ready_o   (don_ready),
        .alloc_valid_o (alloc_valid),
        .alloc_hit_o   (alloc_hit),
        .alloc_type_o  (alloc_type),
        .alloc_ready_i (alloc_ready),
        .pend_o        (pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [2:0] t);
        req_valid = 1'b1;
        req_type  = t;
        tick();
        req_valid = 1'b0;
    endtask

    // Offer a donor, then count edges until the consumer first samples
    // alloc_valid=1 (hit at k: 2+(7-k); miss: 9). Result is then taken.
    task automatic run_donor(input string tag, input logic [2:0] t, input logic eh,
                             input logic [2:0] et, input int el);
        int lat;
        chk({tag, "_dready"}, 32'(don_ready), 32'd1);
        don_valid = 1'b1;
        don_type  = t;
        tick();
        don_valid = 1'b0;
        chk({tag, "_busy"}, 32'({alloc_valid, don_ready}), 32'b00);
        lat = 0;
        while (!alloc_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat + 1), 32'(el));
        chk({tag, "_hit"}, 32'(alloc_hit), 32'(eh));
        chk({tag, "_type"}, 32'(alloc_type), 32'(et));
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
        chk({tag, "_done"}, 32'({alloc_valid, don_ready}), 32'b01);
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid   = 1'b0;
        req_type    = 3'd0;
        don_valid   = 1'b0;
        don_type    = 3'd0;
        alloc_ready = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Reset state
        chk("rst_pend",   32'(pend), 32'h00);
        chk("rst_dready", 32'(don_ready), 32'd1);
        chk("rst_rready", 32'(req_ready), 32'd1);
        chk("rst_avalid", 32'(alloc_valid), 32'd0);
        chk("rst_ahit",   32'(alloc_hit), 32'd0);
        chk("rst_atype",  32'(alloc_type), 32'd0);

        // Basic enqueue
        enq(3'd3);
        chk("enq3_a", 32'(pend), 32'h08);
        enq(3'd3);
        chk("enq3_b", 32'(pend), 32'h08);

        // Universal donor O- with 2, 3, 5 waiting -> 5 (highest)
        enq(3'd2);
        enq(3'd5);
        chk("univ_pend", 32'(pend), 32'h2C);
        run_donor("univ", 3'd0, 1'b1, 3'd5, 4);
        chk("univ_after", 32'(pend), 32'h0C);

        // Drain 3 (twice) and 2
        run_donor("ab_neg1", 3'd3, 1'b1, 3'd3, 6);
        chk("ab_neg1_pend", 32'(pend), 32'h0C);
        run_donor("ab_neg2", 3'd3, 1'b1, 3'd3, 6);
        chk("ab_neg2_pend", 32'(pend), 32'h04);
        run_donor("a_neg", 3'd2, 1'b1, 3'd2, 7);
        chk("a_neg_pend", 32'(pend), 32'h00);

        // Rh rule: B+ donor cannot serve B- patient
        enq(3'd1);
        chk("rh_pend", 32'(pend), 32'h02);
        run_donor("rh_miss", 3'd5, 1'b0, 3'd0, 9);
        chk("rh_after", 32'(pend), 32'h02);
        run_donor("b_neg", 3'd1, 1'b1, 3'd1, 8);
        chk("b_neg_pend", 32'(pend), 32'h00);

        // ABO rule
        enq(3'd6);
        enq(3'd7);
        chk("abo_pend", 32'(pend), 32'hC0);
        run_donor("o_pos", 3'd4, 1'b1, 3'd7, 2);
        chk("o_pos_pend", 32'(pend), 32'h40);
        run_donor("a_pos", 3'd6, 1'b1, 3'd6, 3);
        chk("a_pos_pend", 32'(pend), 32'h00);
        enq(3'd6);
        run_donor("b_to_a", 3'd5, 1'b0, 3'd0, 9);
        chk("b_to_a_pend", 32'(pend), 32'h40);
        run_donor("a_pos2", 3'd6, 1'b1, 3'd6, 3);
        chk("a_pos2_pend", 32'(pend), 32'h00);

        // Saturation of count[7]
        req_type  = 3'd7;
        req_valid = 1'b1;
        repeat (15) tick();
        chk("sat_ready", 32'(req_ready), 32'd0);
        chk("sat_cnt",   32'(dut.cnt_q[7]), 32'd15);
        chk("sat_pend",  32'(pend), 32'h80);
        req_type = 3'd0;
        #1;
        chk("sat_other_ready", 32'(req_ready), 32'd1);
        req_type = 3'd7;

        // Collision: full counter refuses enqueue at the decrement edge
        don_valid = 1'b1;
        don_type  = 3'd7;
        tick();
        don_valid = 1'b0;
        chk("col_scan_ready", 32'(req_ready), 32'd0);
        tick();
        chk("col_avalid", 32'(alloc_valid), 32'd1);
        chk("col_type",   32'({alloc_hit, alloc_type}), 32'b1111);
        chk("col_cnt",    32'(dut.cnt_q[7]), 32'd14);
        chk("col_ready",  32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Backpressure: result held while alloc_ready=0, extra donor ignored
        don_valid = 1'b1;
        don_type  = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", 32'({alloc_valid, alloc_hit, alloc_type, don_ready}), 32'b111110);
        end
        don_valid   = 1'b0;
        alloc_ready = 1'b1;
        tick();
        alloc_ready = 1'b0;
        chk("bp_release", 32'({alloc_valid, don_ready}), 32'b01);
        chk("bp_cnt", 32'(dut.cnt_q[7]), 32'd14);

        // Reset during SCAN: donor abandoned, counts cleared, no result
        don_valid = 1'b1;
        don_type  = 3'd0;
        tick();
        don_valid = 1'b0;
        chk("rs_in_scan", 32'({alloc_valid, don_ready}), 32'b00);
        rst_ni = 1'b0;
        #1;
        chk("rs_async", 32'({pend, don_ready, alloc_valid}), 32'b0000000010);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_result", 32'(alloc_valid), 32'd0);
        end
        chk("rs_cnt",  32'(dut.cnt_q[7]), 32'd0);
        chk("rs_pend", 32'(pend), 32'h00);
        chk("rs_ready", 32'({don_ready, req_ready}), 32'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
